// File: rtl/gemm_activation_streamer.sv
// Feeds activation vectors into a fixed-weight GEMM one per cycle and collects the
// matching GEMM outputs into a credit-protected result FIFO in acceptance order.
module gemm_activation_streamer #(
  parameter int SA_SIZE                = 3,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int LATENCY                = 2 * SA_SIZE,
  parameter int RES_FIFO_DEPTH         = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] in_data,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] gemm_act_in,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] gemm_act_out,
  input  logic                                      gemm_output_valid,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] out_data,
  output logic                                      idle,
  output logic                                      protocol_err
);

  localparam int VEC_W = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int CNT_W = $clog2(RES_FIFO_DEPTH + 1);
  localparam int PTR_W = (RES_FIFO_DEPTH > 1) ? $clog2(RES_FIFO_DEPTH) : 1;
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  logic               accept;
  logic               retire;
  logic               pop;
  logic [LATENCY-1:0] tag;
  logic [INF_W-1:0]   inflight_cnt;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [SUM_W-1:0]   credit_used;
  logic [VEC_W-1:0]   fifo_mem [RES_FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RES_FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Every accepted vector reserves a FIFO slot up front, so a retire can never hit a full FIFO.
  assign credit_used = SUM_W'(fifo_count) + SUM_W'(inflight_cnt);
  assign in_ready    = !reset && (credit_used < SUM_W'(RES_FIFO_DEPTH));
  assign accept      = in_valid & in_ready;
  assign gemm_act_in = accept ? in_data : '0;
  assign retire      = tag[LATENCY-1];
  assign out_valid   = (fifo_count != '0);
  assign pop         = out_valid & out_ready;
  assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
  assign idle        = (inflight_cnt == '0) && (fifo_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag          <= '0;
      inflight_cnt <= '0;
    end else begin
      tag[0] <= accept;
      for (int k = 1; k < LATENCY; k++) begin
        tag[k] <= tag[k-1];
      end
      inflight_cnt <= inflight_cnt + INF_W'(accept) - INF_W'(retire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (retire) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(retire) - CNT_W'(pop);
      if (retire && !gemm_output_valid) protocol_err <= 1'b1;
    end
  end

  // Storage is left unreset; out_data is masked until an entry is valid.
  always_ff @(posedge clk) begin
    if (retire) fifo_mem[wr_ptr] <= gemm_act_out;
  end

endmodule

// File: tb/tb_gemm_activation_streamer.sv
// Directed bench for gemm_activation_streamer with a behavioural diag(3,2) GEMM of latency 4.
module tb_gemm_activation_streamer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] gemm_act_in;
  logic [15:0] gemm_act_out;
  logic        gemm_output_valid;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        idle;
  logic        protocol_err;

  int errors = 0;
  int checks = 0;
  int accepted;
  int idx;
  int beats;

  logic [15:0] gpipe [4];

  gemm_activation_streamer #(
    .SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .LATENCY(4), .RES_FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .gemm_act_in(gemm_act_in), .gemm_act_out(gemm_act_out),
    .gemm_output_valid(gemm_output_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .idle(idle), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gemm_mul(input logic [15:0] a);
    logic [7:0] e0;
    logic [7:0] e1;
    e0 = a[7:0] * 8'd3;
    e1 = a[15:8] * 8'd2;
    return {e1, e0};
  endfunction

  // External GEMM stand-in; deliberately not reset so stale data sits in it across a reset.
  always @(posedge clk) begin
    gpipe[0] <= gemm_mul(gemm_act_in);
    for (int k = 1; k < 4; k++) gpipe[k] <= gpipe[k-1];
  end
  assign gemm_act_out = gpipe[3];

  function automatic logic [15:0] vec(input int i);
    return {8'(i + 2), 8'(i + 1)};
  endfunction

  function automatic logic [15:0] res(input int i);
    return {8'(2 * (i + 2)), 8'(3 * (i + 1))};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && dut.retire) begin
      checks++;
      assert ((dut.fifo_count == 4'd8) === 1'b0) else begin
        errors++;
        $error("[TB] FAIL push_when_full: observed full=1 expected 0");
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; gemm_output_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_idle", idle, 1);
    check_output("rst_perr", protocol_err, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_output("rel_in_ready", in_ready, 1);

    // single vector
    apply_stimulus(1, {8'd5, 8'd2}, 1);
    check_output("t1_ready", in_ready, 1);
    check_output("t1_act_in", gemm_act_in, 16'h0502);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(0, '0, 1);
      check_output("t1_valid", out_valid, (k == 5) ? 16'd1 : 16'd0);
      if (k == 5) check_output("t1_data", out_data, 16'h0A06);
    end
    check_output("t1_idle", idle, 1);

    // back-to-back
    apply_stimulus(1, {8'd5, 8'd2}, 1);
    check_output("t2_ready0", in_ready, 1);
    apply_stimulus(1, {8'd2, 8'd3}, 1);
    check_output("t2_ready1", in_ready, 1);
    for (int k = 2; k <= 7; k++) begin
      apply_stimulus(0, '0, 1);
      check_output("t2_ready", in_ready, 1);
      check_output("t2_valid", out_valid, (k == 5 || k == 6) ? 16'd1 : 16'd0);
      if (k == 5) check_output("t2_data0", out_data, 16'h0A06);
      if (k == 6) check_output("t2_data1", out_data, 16'h0409);
    end

    // backpressure
    accepted = 0;
    idx = 0;
    for (int n = 0; n < 20; n++) begin
      apply_stimulus(idx < 10, vec(idx), 0);
      if (in_valid && in_ready) begin
        accepted++;
        idx++;
      end
      if (n == 15) check_output("t3_hold_data", out_data, res(0));
    end
    check_output("t3_accepted", 16'(accepted), 16'd8);
    check_output("t3_ready_low", in_ready, 0);
    check_output("t3_hold_valid", out_valid, 1);
    check_output("t3_hold_data2", out_data, res(0));
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, '0, 1);
      check_output("t3_drain_valid", out_valid, 1);
      check_output("t3_drain_data", out_data, res(i));
      if (i == 0) check_output("t3_ready_at_pop", in_ready, 0);
      if (i == 1) check_output("t3_ready_after_pop", in_ready, 1);
    end
    apply_stimulus(0, '0, 1);
    check_output("t3_empty", out_valid, 0);
    check_output("t3_idle", idle, 1);

    // bubbles
    apply_stimulus(1, 16'h0101, 1);
    check_output("t4_act0", gemm_act_in, 16'h0101);
    apply_stimulus(0, 16'h7777, 1);
    check_output("t4_gap1", gemm_act_in, 16'h0000);
    apply_stimulus(0, 16'h7777, 1);
    check_output("t4_gap2", gemm_act_in, 16'h0000);
    apply_stimulus(1, 16'h0004, 1);
    check_output("t4_act3", gemm_act_in, 16'h0004);
    beats = 0;
    for (int k = 4; k <= 12; k++) begin
      apply_stimulus(0, '0, 1);
      if (out_valid) beats++;
      check_output("t4_valid", out_valid, (k == 5 || k == 8) ? 16'd1 : 16'd0);
      if (k == 5) check_output("t4_data0", out_data, 16'h0203);
      if (k == 8) check_output("t4_data1", out_data, 16'h000C);
    end
    check_output("t4_beats", 16'(beats), 16'd2);

    // reset mid-operation: 2 results in FIFO, 3 vectors in flight
    apply_stimulus(1, vec(0), 0);
    apply_stimulus(1, vec(1), 0);
    for (int k = 2; k <= 5; k++) apply_stimulus(0, '0, 0);
    for (int k = 6; k <= 8; k++) begin
      apply_stimulus(1, vec(k), 0);
      check_output("t5_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_output("t5_rst_valid", out_valid, 0);
    check_output("t5_rst_idle", idle, 1);
    check_output("t5_rst_ready", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(0, '0, 1);
      check_output("t5_no_stale", out_valid, 0);
    end
    check_output("t5_idle", idle, 1);

    // protocol error path
    gemm_output_valid = 1'b0;
    apply_stimulus(1, {8'd5, 8'd2}, 1);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(0, '0, 1);
      if (k == 4) check_output("t6_perr_before", protocol_err, 0);
      if (k == 5) begin
        check_output("t6_perr_set", protocol_err, 1);
        check_output("t6_pushed_valid", out_valid, 1);
        check_output("t6_pushed_data", out_data, 16'h0A06);
      end
    end
    gemm_output_valid = 1'b1;
    for (int k = 0; k < 3; k++) apply_stimulus(0, '0, 1);
    check_output("t6_perr_sticky", protocol_err, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_output("t6_perr_cleared", protocol_err, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
